adder_serial_sign: RTL and testbench

Multi-cycle signed 32-bit adder for the RISC-V datapath. It is the additive counterpart of the signed subtractor: it computes rd = rs1 + rs2 in two's complement, one DIGIT-bit slice per clock, and reports carry-out and signed overflow. A valid/ready handshake on both sides lets it sit behind the decode stage as an area-saving alternative to the single-cycle adder chain. It accepts one operation at a time; there is no pipelining.

---
 rtl/adder_serial_sign_if.sv | 33 +++
 rtl/adder_serial_sign.sv | 118 +++++++++++
 tb/tb_adder_serial_sign.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/adder_serial_sign_if.sv
// -----------------------------------------------------------------------------
// adder_serial_sign_if
// Handshake bundle for the serial signed adder.
//   valid_i / ready_o : operand request channel (requester -> adder)
//   rs1_i / rs2_i     : signed operands, captured when the adder accepts
//   valid_o / ready_i : result channel (adder -> consumer)
//   rd_o              : sum modulo 2^WIDTH
//   carry_o / ovf_o   : unsigned carry-out and signed overflow of the sum
// Modports: master = requester/consumer side, slave = the adder itself.
// -----------------------------------------------------------------------------
interface adder_serial_sign_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] rs1_i;
   logic [WIDTH-1:0] rs2_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] rd_o;
   logic             carry_o;
   logic             ovf_o;

   modport master (
      output valid_i, rs1_i, rs2_i, ready_i,
      input  ready_o, valid_o, rd_o, carry_o, ovf_o
   );

   modport slave (
      input  valid_i, rs1_i, rs2_i, ready_i,
      output ready_o, valid_o, rd_o, carry_o, ovf_o
   );
endinterface

// File: rtl/adder_serial_sign.sv
// -----------------------------------------------------------------------------
// adder_serial_sign
// Multi-cycle signed adder: rd = rs1 + rs2, DIGIT bits per clock, LSB slice
// first. One operation in flight; WIDTH/DIGIT cycles of RUN per operation.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : adder_serial_sign_if.slave (operand and result handshakes)
// -----------------------------------------------------------------------------
module adder_serial_sign #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   adder_serial_sign_if.slave   bus
);
   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_q;       // augend shift register
   logic [WIDTH-1:0]   b_q;       // addend shift register
   logic [WIDTH-1:0]   acc_q;     // partial sum, filled from the top
   logic               carry_q;   // carry between slices
   logic [CNT_W-1:0]   cnt;
   logic               s1_q;      // captured operand sign bits
   logic               s2_q;

   logic [WIDTH-1:0]   rd_q;
   logic               carry_out_q;
   logic               ovf_q;

   logic [DIGIT:0]     slice;
   logic [WIDTH-1:0]   acc_next;

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned; that is what keeps a latch from being inferred.
   always_comb begin
      slice    = '0;
      acc_next = acc_q;
      slice    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
      // New slice enters at the top; after N slices the LSB slice sits at bit 0.
      acc_next = WIDTH'({slice[DIGIT-1:0], acc_q} >> DIGIT);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   // NOTE: the datapath registers are reset along with the FSM; the result
   // outputs must read zero out of reset and there is no memory array here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         cnt         <= '0;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         rd_q        <= '0;
         carry_out_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.valid_i) begin
                  a_q     <= bus.rs1_i;
                  b_q     <= bus.rs2_i;
                  s1_q    <= bus.rs1_i[WIDTH-1];
                  s2_q    <= bus.rs2_i[WIDTH-1];
                  acc_q   <= '0;
                  carry_q <= 1'b0;
                  cnt     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               acc_q   <= acc_next;
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               carry_q <= slice[DIGIT];
               cnt     <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(N - 1)) begin
                  // Results are published only here so they stay frozen
                  // through IDLE and RUN of the next operation.
                  rd_q        <= acc_next;
                  carry_out_q <= slice[DIGIT];
                  ovf_q       <= (s1_q == s2_q) && (acc_next[WIDTH-1] != s1_q);
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.ready_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake flags decode straight from the state register: no path from
   // valid_i or ready_i reaches them combinationally.
   assign bus.ready_o = (state == IDLE);
   assign bus.valid_o = (state == DONE);
   assign bus.rd_o    = rd_q;
   assign bus.carry_o = carry_out_q;
   assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_adder_serial_sign.sv
// -----------------------------------------------------------------------------
// tb_adder_serial_sign
// Directed self-checking bench for adder_serial_sign (WIDTH=32, DIGIT=4).
// Inputs change 1 ns after a rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_adder_serial_sign;
   localparam int WIDTH = 32;
   localparam int LAT   = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   lat;

   adder_serial_sign_if #(.WIDTH(WIDTH)) bus ();

   adder_serial_sign #(.WIDTH(WIDTH), .DIGIT(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until valid_o is seen; bounded so a stuck DUT still ends.
   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (bus.valid_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      if (bus.valid_o !== 1'b1) check({tag, "_timeout"}, 64'(bus.valid_o), 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_rd, input logic e_c, input logic e_v);
      bus.rs1_i   = a;
      bus.rs2_i   = b;
      bus.valid_i = 1'b1;
      step();
      bus.valid_i = 1'b0;
      check({tag, "_ready_low"}, 64'(bus.ready_o), 64'd0);
      wait_valid(tag, lat);
      check({tag, "_lat"}, 64'(lat), 64'(LAT));
      check({tag, "_rd"}, 64'(bus.rd_o), 64'(e_rd));
      check({tag, "_carry"}, 64'(bus.carry_o), 64'(e_c));
      check({tag, "_ovf"}, 64'(bus.ovf_o), 64'(e_v));
      bus.ready_i = 1'b1;
      step();
      bus.ready_i = 1'b0;
      check({tag, "_valid_drop"}, 64'(bus.valid_o), 64'd0);
      check({tag, "_ready_back"}, 64'(bus.ready_o), 64'd1);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.rs1_i   = '0;
      bus.rs2_i   = '0;
      rst         = 1'b1;
      #1;
      check("rst_ready", 64'(bus.ready_o), 64'd1);
      check("rst_valid", 64'(bus.valid_o), 64'd0);
      check("rst_rd", 64'(bus.rd_o), 64'd0);
      check("rst_carry", 64'(bus.carry_o), 64'd0);
      check("rst_ovf", 64'(bus.ovf_o), 64'd0);
      repeat (2) step();
      rst = 1'b0;
      step();
      check("post_rst_ready", 64'(bus.ready_o), 64'd1);

      // Arithmetic corner cases
      run_op("p_plus_n",  32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002, 1'b1, 1'b0);
      run_op("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
      run_op("neg_ovf",   32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
      run_op("m1_m1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);

      // Back-pressure with junk operands offered during RUN
      bus.rs1_i   = 32'h0000_0100;
      bus.rs2_i   = 32'h0000_0200;
      bus.valid_i = 1'b1;
      step();
      bus.rs1_i = 32'hDEAD_BEEF;
      bus.rs2_i = 32'h7FFF_FFFF;
      step();
      step();
      bus.valid_i = 1'b0;
      wait_valid("bp", lat);
      check("bp_lat", 64'(lat), 64'd6);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 64'(bus.valid_o), 64'd1);
         check("bp_ready", 64'(bus.ready_o), 64'd0);
         check("bp_rd", 64'(bus.rd_o), 64'h300);
         check("bp_carry", 64'(bus.carry_o), 64'd0);
         check("bp_ovf", 64'(bus.ovf_o), 64'd0);
         step();
      end
      bus.ready_i = 1'b1;
      step();
      bus.ready_i = 1'b0;
      check("bp_done", 64'(bus.ready_o), 64'd1);

      // Reset in the middle of RUN discards the operation
      bus.rs1_i   = 32'h1234_5678;
      bus.rs2_i   = 32'h1111_1111;
      bus.valid_i = 1'b1;
      step();
      bus.valid_i = 1'b0;
      repeat (3) step();
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ready", 64'(bus.ready_o), 64'd1);
      check("mid_rst_valid", 64'(bus.valid_o), 64'd0);
      check("mid_rst_rd", 64'(bus.rd_o), 64'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("mid_rst_no_valid", 64'(bus.valid_o), 64'd0);
         step();
      end
      run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);

      // Back-to-back with valid_i and ready_i held high
      bus.rs1_i   = 32'h0000_0010;
      bus.rs2_i   = 32'h0000_0020;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b1;
      step();
      bus.rs1_i = 32'hFFFF_FFFF;
      bus.rs2_i = 32'h0000_0001;
      wait_valid("b2b1", lat);
      check("b2b1_lat", 64'(lat), 64'(LAT));
      check("b2b1_rd", 64'(bus.rd_o), 64'h30);
      step();
      check("b2b_hs_valid", 64'(bus.valid_o), 64'd0);
      check("b2b_hs_ready", 64'(bus.ready_o), 64'd1);
      step();
      check("b2b2_accept", 64'(bus.ready_o), 64'd0);
      bus.valid_i = 1'b0;
      wait_valid("b2b2", lat);
      check("b2b2_lat", 64'(lat), 64'(LAT));
      check("b2b2_rd", 64'(bus.rd_o), 64'h0);
      check("b2b2_carry", 64'(bus.carry_o), 64'd1);
      check("b2b2_ovf", 64'(bus.ovf_o), 64'd0);
      step();
      bus.ready_i = 1'b0;
      check("b2b2_done", 64'(bus.ready_o), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
